// File: rtl/main_data_scalefac_parser.sv
// Part2 scalefactor decoder and part3 bit forwarder for one granule/channel of main_data.
// Define PARSER_HUFF_FWD_EN to forward part3 bits to the Huffman decoder; otherwise they are dropped.
module main_data_scalefac_parser #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LEN_W  = 12,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  side_info_iv,
  input  logic [LEN_W-1:0]      part2_3_length,
  input  logic [3:0]            scalefac_compress,
  input  logic                  window_switching_flag,
  input  logic                  mixed_block_flag,
  input  logic [1:0]            block_type,
  input  logic [3:0]            scfsi,
  input  logic                  gr,
  input  logic [CH_W-1:0]       ch,
  input  logic                  fifo_iv,
  input  logic                  fifo_id,
  output logic                  fifo_rd,
  input  logic                  huff_ready,
  output logic                  huff_ov,
  output logic                  huff_od,
  output logic                  huff_last,
  output logic [LEN_W-1:0]      part2_length,
  output logic [20:0][3:0]      scalefac_l,
  output logic [11:0][2:0][3:0] scalefac_s,
  output logic                  done,
  output logic                  trunc_err
);

  typedef enum logic [1:0] {StIdle, StScf, StHuff, StDone} state_e;
  typedef enum logic [1:0] {ModeLong, ModeShort, ModeMixed} mode_e;

  function automatic logic [2:0] slen1_of(input logic [3:0] c);
    case (c)
      4'd4, 4'd11, 4'd12, 4'd13: slen1_of = 3'd3;
      4'd5, 4'd6, 4'd7:          slen1_of = 3'd1;
      4'd8, 4'd9, 4'd10:         slen1_of = 3'd2;
      4'd14, 4'd15:              slen1_of = 3'd4;
      default:                   slen1_of = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] slen2_of(input logic [3:0] c);
    case (c)
      4'd1, 4'd5, 4'd8, 4'd11:          slen2_of = 3'd1;
      4'd2, 4'd6, 4'd9, 4'd12, 4'd14:   slen2_of = 3'd2;
      4'd3, 4'd7, 4'd10, 4'd13, 4'd15:  slen2_of = 3'd3;
      default:                          slen2_of = 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] grp_of(input int k);
    if (k < 6)       grp_of = 2'd0;
    else if (k < 11) grp_of = 2'd1;
    else if (k < 16) grp_of = 2'd2;
    else             grp_of = 2'd3;
  endfunction

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_in;
  logic [CH_W-1:0]       ch_q;
  logic [LEN_W-1:0]      len_q;
  logic [2:0]            s1_q, s2_q, s1_in, s2_in;
  logic [35:0]           rem_q, rem_d, rem_next, init_mask;
  logic [20:0]           init_keep;
  logic [1:0]            bpos_q, bpos_d;
  logic [3:0]            acc_q, acc_d, val;
  logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_inc, part2_len_q, part2_len_d;
  logic                  trunc_q, trunc_d;
  logic [20:0][3:0]      scf_l_q, scf_l_d, keep_src;
  logic [11:0][2:0][3:0] scf_s_q, scf_s_d;
  logic [20:0][3:0]      store_q [NUM_CH];

  logic [5:0]            cur, sidx;
  logic                  cur_short;
  logic [3:0]            cur_sfb_s;
  logic [1:0]            cur_win;
  logic [2:0]            cur_slen;

  // Slot mask: one bit per scalefactor value still to be read, in bitstream order.
  always_comb begin
    s1_in = slen1_of(scalefac_compress);
    s2_in = slen2_of(scalefac_compress);
    if (!(window_switching_flag && (block_type == 2'd2))) mode_in = ModeLong;
    else if (mixed_block_flag)                            mode_in = ModeMixed;
    else                                                  mode_in = ModeShort;
    init_mask = '0;
    init_keep = '0;
    case (mode_in)
      ModeLong: begin
        for (int k = 0; k < 21; k++) begin
          init_keep[k] = gr && scfsi[grp_of(k)];
          init_mask[k] = !init_keep[k] && (((k < 11) ? s1_in : s2_in) != 3'd0);
        end
      end
      ModeShort: begin
        for (int k = 0; k < 36; k++) init_mask[k] = ((k < 18) ? s1_in : s2_in) != 3'd0;
      end
      default: begin
        for (int k = 0; k < 35; k++) init_mask[k] = ((k < 17) ? s1_in : s2_in) != 3'd0;
      end
    endcase
  end

  assign keep_src = ((state_q == StDone) && (ch_q == ch)) ? scf_l_q : store_q[ch];

  // Lowest pending slot; mixed short slots are offset so that slot 8 maps to sfb3/window0.
  always_comb begin
    cur = '0;
    for (int k = 35; k >= 0; k--) begin
      if (rem_q[k]) cur = 6'(k);
    end
    sidx      = (mode_q == ModeMixed) ? cur + 6'd1 : cur;
    cur_short = (mode_q == ModeShort) || ((mode_q == ModeMixed) && (cur >= 6'd8));
    cur_sfb_s = 4'(sidx / 6'd3);
    cur_win   = 2'(sidx % 6'd3);
    if (cur_short) cur_slen = (sidx < 6'd18) ? s1_q : s2_q;
    else           cur_slen = (cur < 6'd11) ? s1_q : s2_q;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    rem_next    = rem_q;
    bpos_d      = bpos_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    part2_len_d = part2_len_q;
    trunc_d     = trunc_q;
    scf_l_d     = scf_l_q;
    scf_s_d     = scf_s_q;
    fifo_rd     = 1'b0;
    huff_ov     = 1'b0;
    huff_od     = 1'b0;
    huff_last   = 1'b0;
    val         = {acc_q[2:0], fifo_id};
    cnt_inc     = bit_cnt_q + 1'b1;
    case (state_q)
      StScf: begin
        if (rem_q == '0) begin
          part2_len_d = bit_cnt_q;
          state_d     = (bit_cnt_q == len_q) ? StDone : StHuff;
        end else if (bit_cnt_q == len_q) begin
          trunc_d     = 1'b1;
          part2_len_d = bit_cnt_q;
          state_d     = StDone;
        end else begin
          fifo_rd = 1'b1;
          if (fifo_iv) begin
            bit_cnt_d = cnt_inc;
            acc_d     = val;
            bpos_d    = bpos_q + 2'd1;
            if (({1'b0, bpos_q} + 3'd1) == cur_slen) begin
              rem_next[cur] = 1'b0;
              bpos_d        = '0;
              acc_d         = '0;
              if (cur_short) scf_s_d[cur_sfb_s][cur_win] = val;
              else           scf_l_d[cur[4:0]] = val;
            end
            rem_d = rem_next;
            if (rem_next == '0) begin
              part2_len_d = cnt_inc;
              state_d     = (cnt_inc == len_q) ? StDone : StHuff;
            end else if (cnt_inc == len_q) begin
              trunc_d     = 1'b1;
              part2_len_d = cnt_inc;
              state_d     = StDone;
            end
          end
        end
      end
      StHuff: begin
`ifdef PARSER_HUFF_FWD_EN
        fifo_rd   = huff_ready;
        huff_ov   = fifo_iv;
        huff_od   = fifo_id;
        huff_last = fifo_iv && (cnt_inc == len_q);
`else
        fifo_rd   = 1'b1;
`endif
        if (fifo_iv && fifo_rd) begin
          bit_cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = state_q;
    endcase

    // New side info wins in every state; nothing is consumed in the restart cycle.
    if (side_info_iv) begin
      fifo_rd     = 1'b0;
      huff_ov     = 1'b0;
      huff_last   = 1'b0;
      state_d     = StScf;
      rem_d       = init_mask;
      bpos_d      = '0;
      acc_d       = '0;
      bit_cnt_d   = '0;
      part2_len_d = '0;
      trunc_d     = 1'b0;
      scf_s_d     = '0;
      for (int k = 0; k < 21; k++) scf_l_d[k] = init_keep[k] ? keep_src[k] : 4'd0;
    end
  end

`ifndef PARSER_HUFF_FWD_EN
  logic unused_huff_ready;
  assign unused_huff_ready = huff_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeLong;
      ch_q        <= '0;
      len_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rem_q       <= '0;
      bpos_q      <= '0;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      part2_len_q <= '0;
      trunc_q     <= 1'b0;
      scf_l_q     <= '0;
      scf_s_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) store_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      bpos_q      <= bpos_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      part2_len_q <= part2_len_d;
      trunc_q     <= trunc_d;
      scf_l_q     <= scf_l_d;
      scf_s_q     <= scf_s_d;
      if (side_info_iv) begin
        mode_q <= mode_in;
        ch_q   <= ch;
        len_q  <= part2_3_length;
        s1_q   <= s1_in;
        s2_q   <= s2_in;
      end
      if (state_q == StDone) store_q[ch_q] <= scf_l_q;
    end
  end

  assign part2_length = part2_len_q;
  assign scalefac_l   = scf_l_q;
  assign scalefac_s   = scf_s_q;
  assign done         = (state_q == StDone);
  assign trunc_err    = trunc_q;

endmodule

// File: tb/tb_main_data_scalefac_parser.sv
// Directed and randomized bench for main_data_scalefac_parser with a list-based reference model.
module tb_main_data_scalefac_parser;

  logic                  clk = 1'b0;
  logic                  rst, side_info_iv;
  logic [11:0]           part2_3_length;
  logic [3:0]            scalefac_compress, scfsi;
  logic                  window_switching_flag, mixed_block_flag, gr;
  logic [1:0]            block_type;
  logic [0:0]            ch;
  logic                  fifo_iv, fifo_id, fifo_rd, huff_ready, huff_ov, huff_od, huff_last;
  logic [11:0]           part2_length;
  logic [20:0][3:0]      scalefac_l;
  logic [11:0][2:0][3:0] scalefac_s;
  logic                  done, trunc_err;

  always #5 clk = ~clk;

  main_data_scalefac_parser #(.NUM_CH(2), .LEN_W(12)) dut (
    .clk(clk), .rst(rst), .side_info_iv(side_info_iv), .part2_3_length(part2_3_length),
    .scalefac_compress(scalefac_compress), .window_switching_flag(window_switching_flag),
    .mixed_block_flag(mixed_block_flag), .block_type(block_type), .scfsi(scfsi), .gr(gr),
    .ch(ch), .fifo_iv(fifo_iv), .fifo_id(fifo_id), .fifo_rd(fifo_rd), .huff_ready(huff_ready),
    .huff_ov(huff_ov), .huff_od(huff_od), .huff_last(huff_last), .part2_length(part2_length),
    .scalefac_l(scalefac_l), .scalefac_s(scalefac_s), .done(done), .trunc_err(trunc_err)
  );

  int vectors, miscompares;
  int sl1_t [16] = '{0, 0, 0, 0, 3, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};
  int sl2_t [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 2, 3};
  bit                    src[$];
  int                    rd_ptr;
  logic [20:0][3:0]      m_store [2];
  logic [20:0][3:0]      exp_l;
  logic [11:0][2:0][3:0] exp_s;
  int                    exp_p2;
  bit                    exp_trunc;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Builds the read list from the band rules, then pulls values from src MSB first.
  task automatic model(input int len, input int comp, input bit w, input bit m, input int b,
                       input bit [3:0] sf, input bit g, input int c);
    int s1, s2, pos, v, sl, grp;
    bit sh;
    int q_sh[$], q_sfb[$], q_win[$], q_sl[$];
    s1 = sl1_t[comp];
    s2 = sl2_t[comp];
    sh = w && (b == 2);
    exp_l = '0;
    exp_s = '0;
    if (!sh) begin
      for (int sfb = 0; sfb < 21; sfb++) begin
        grp = (sfb < 6) ? 0 : (sfb < 11) ? 1 : (sfb < 16) ? 2 : 3;
        if (g && sf[grp]) exp_l[sfb] = m_store[c][sfb];
        else begin
          q_sh.push_back(0); q_sfb.push_back(sfb); q_win.push_back(0);
          q_sl.push_back((sfb < 11) ? s1 : s2);
        end
      end
    end else begin
      if (m) begin
        for (int sfb = 0; sfb < 8; sfb++) begin
          q_sh.push_back(0); q_sfb.push_back(sfb); q_win.push_back(0); q_sl.push_back(s1);
        end
      end
      for (int sfb = (m ? 3 : 0); sfb < 12; sfb++) begin
        for (int w2 = 0; w2 < 3; w2++) begin
          q_sh.push_back(1); q_sfb.push_back(sfb); q_win.push_back(w2);
          q_sl.push_back((sfb < 6) ? s1 : s2);
        end
      end
    end
    pos = 0;
    exp_trunc = 0;
    for (int i = 0; i < q_sl.size(); i++) begin
      sl = q_sl[i];
      if (sl != 0) begin
        if (pos + sl > len) begin
          exp_trunc = 1;
          pos = len;
          break;
        end
        v = 0;
        for (int j = 0; j < sl; j++) v = v * 2 + int'(src[pos + j]);
        pos += sl;
        if (q_sh[i] != 0) exp_s[q_sfb[i]][q_win[i]] = v[3:0];
        else              exp_l[q_sfb[i]] = v[3:0];
      end
    end
    exp_p2 = pos;
  endtask

  task automatic run_granule(input string tag, input int len, input int comp, input bit w,
                             input bit m, input int b, input bit [3:0] sf, input bit g,
                             input int c, input bit gaps, input int abort_at);
    bit fin;
    int done_cyc, last_cyc;
`ifdef PARSER_HUFF_FWD_EN
    int hcnt;
    bit hok;
    bit hb[$];
    bit hl[$];
`else
    bit any_huff;
`endif
    src.delete();
    for (int i = 0; i < len + 8; i++) src.push_back(1'($urandom_range(0, 1)));
    model(len, comp, w, m, b, sf, g, c);
    @(negedge clk);
    side_info_iv          = 1'b1;
    part2_3_length        = len[11:0];
    scalefac_compress     = comp[3:0];
    window_switching_flag = w;
    mixed_block_flag      = m;
    block_type            = b[1:0];
    scfsi                 = sf;
    gr                    = g;
    ch                    = c[0:0];
    fifo_iv               = 1'b0;
    huff_ready            = 1'b1;
    rd_ptr   = 0;
    fin      = 0;
    done_cyc = -1;
    last_cyc = 0;
`ifndef PARSER_HUFF_FWD_EN
    any_huff = 0;
`endif
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      side_info_iv = 1'b0;
      fifo_iv      = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      huff_ready   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_id      = src[rd_ptr];
      #1;
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        break;
      end
`ifdef PARSER_HUFF_FWD_EN
      if (huff_ov && huff_ready) begin
        hb.push_back(huff_od);
        hl.push_back(huff_last);
      end
`else
      if (huff_ov || huff_od || huff_last) any_huff = 1;
`endif
      if (fifo_iv && fifo_rd) begin
        rd_ptr++;
        last_cyc = cyc;
        if (rd_ptr == abort_at) break;
      end
    end
    if (abort_at >= 0) begin
      check({tag, "_no_done"}, fin, 0);
    end else begin
      check({tag, "_done"}, fin, 1);
      check({tag, "_latency"}, done_cyc, last_cyc + 1);
      check({tag, "_bits"}, rd_ptr, len);
      check({tag, "_p2len"}, part2_length, exp_p2);
      check({tag, "_trunc"}, trunc_err, exp_trunc);
      check({tag, "_scf_l"}, scalefac_l, exp_l);
      check({tag, "_scf_s"}, scalefac_s, exp_s);
`ifdef PARSER_HUFF_FWD_EN
      hcnt = exp_trunc ? 0 : len - exp_p2;
      hok  = (hb.size() == hcnt);
      for (int i = 0; i < hb.size() && hok; i++) begin
        if (hb[i] != src[exp_p2 + i] || hl[i] != (i == hcnt - 1)) hok = 0;
      end
      check({tag, "_huff_cnt"}, hb.size(), hcnt);
      check({tag, "_huff_seq"}, hok, 1);
`else
      check({tag, "_huff_tied0"}, any_huff, 0);
`endif
      @(negedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
      m_store[c] = exp_l;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_trunc"}, trunc_err, 0);
    check({tag, "_p2len"}, part2_length, 0);
    check({tag, "_scf_l"}, scalefac_l, 0);
    check({tag, "_scf_s"}, scalefac_s, 0);
    check({tag, "_fifo_rd"}, fifo_rd, 0);
    check({tag, "_huff"}, {huff_ov, huff_od, huff_last}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    side_info_iv = 1'b0;
    part2_3_length = '0;
    scalefac_compress = '0;
    window_switching_flag = 1'b0;
    mixed_block_flag = 1'b0;
    block_type = '0;
    scfsi = '0;
    gr = 1'b0;
    ch = '0;
    fifo_iv = 1'b1;
    fifo_id = 1'b1;
    huff_ready = 1'b1;
    m_store[0] = '0;
    m_store[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_granule("long_gr0", 80, 15, 0, 0, 0, 4'b0000, 0, 0, 0, -1);
    check("long_gr0_p2_74", part2_length, 74);
    run_granule("long_gr1", 45, 15, 0, 0, 0, 4'b0101, 1, 0, 0, -1);
    check("long_gr1_p2_35", part2_length, 35);
    run_granule("short", 36, 5, 1, 0, 2, 4'b1111, 1, 0, 0, -1);
    run_granule("mixed", 75, 9, 1, 1, 2, 4'b0000, 0, 1, 0, -1);
    check("mixed_p2_70", part2_length, 70);
    run_granule("trunc", 20, 15, 0, 0, 0, 4'b0000, 0, 1, 0, -1);
    check("trunc_flag", trunc_err, 1);
    run_granule("abort", 80, 15, 0, 0, 0, 4'b0000, 0, 1, 0, 10);
    run_granule("restart", 80, 15, 0, 0, 0, 4'b0000, 0, 1, 1, -1);
    run_granule("bp_long", 100, 14, 0, 0, 0, 4'b0000, 0, 0, 1, -1);
    run_granule("len0", 0, 15, 0, 0, 0, 4'b0000, 0, 0, 0, -1);
    run_granule("len0_c0", 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, -1);

    for (int n = 0; n < 12; n++) begin
      run_granule($sformatf("rnd%0d", n), $urandom_range(0, 120), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                  1'($urandom_range(0, 1)), -1);
    end

    run_granule("pre_rst", 80, 15, 0, 0, 0, 4'b0000, 0, 0, 1, 77);
    @(negedge clk);
    rst = 1'b1;
    fifo_iv = 1'b1;
    fifo_id = 1'b1;
    huff_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_huff");
    m_store[0] = '0;
    m_store[1] = '0;
    run_granule("post_rst", 10, 15, 0, 0, 0, 4'b1111, 1, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_data_scalefac_parser.md
Name: main_data_scalefac_parser

Overview:
- Parametrised successor to the 2-channel main_data parser.
- Consumes the serial main_data bitstream from the bit-reservoir FIFO, one granule/channel at a time, for NUM_CH channels.
- Decodes the part2 scalefactors (long, short, mixed blocks, with scfsi reuse across granules) and forwards the remaining part3 (Huffman) bits to the Huffman decoder through a ready/valid bit stream.
- Pulses done after exactly part2_3_length bits have been consumed.

Parameters:
- NUM_CH, 2, number of channels; per-channel long-scalefactor storage for scfsi reuse (1..2).
- LEN_W, 12, width of part2_3_length and bit counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- side_info_iv  in  1  one-cycle strobe; side-info inputs below valid; starts a granule/channel
- part2_3_length  in  LEN_W  total main_data bits for this granule/channel
- scalefac_compress  in  4  index into slen table
- window_switching_flag  in  1  side info
- mixed_block_flag  in  1  side info
- block_type  in  2  side info
- scfsi  in  4  scfsi[k] = reuse flag for long band group k (0:sfb0-5, 1:6-10, 2:11-15, 3:16-20)
- gr  in  1  granule index
- ch  in  $clog2(NUM_CH) (min 1)  channel index
- fifo_iv  in  1  FIFO bit valid
- fifo_id  in  1  FIFO bit data
- fifo_rd  out  1  ready; a bit is consumed when fifo_iv && fifo_rd
- huff_ready  in  1  Huffman decoder ready
- huff_ov  out  1  forwarded part3 bit valid
- huff_od  out  1  forwarded part3 bit
- huff_last  out  1  marks final part3 bit
- part2_length  out  LEN_W  scalefactor bits actually read; valid with done
- scalefac_l  out  21x4  long scalefactors, sfb 0..20
- scalefac_s  out  12x3x4  short scalefactors [sfb][window]
- done  out  1  one-cycle pulse, granule/channel complete
- trunc_err  out  1  sticky per granule; part2_3_length ended inside the scalefactors

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Per-channel stores and scalefac outputs cleared.
  - Applies identically mid-operation.
- States: IDLE, SCF, HUFF, DONE.
- side_info_iv latches all inputs in any state. An in-progress granule is abandoned without a done pulse. bit_cnt is cleared, trunc_err is cleared, and the state goes to SCF.
  - Band clearing: all scalefac_s bands are cleared. Long bands of the latched ch are cleared unless gr=1, the block is not short, and scfsi[group] is set; those bands are retained.
- slen table, indexed by scalefac_compress 0..15:
  - slen1 = 0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4
  - slen2 = 0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3
- Read order is MSB first per value; each value is zero-extended to 4 bits.
  - Long (not window_switching, or block_type!=2): sfb0-10 use slen1, sfb11-20 use slen2. Groups flagged for reuse (gr=1 only) are skipped entirely.
  - Short, non-mixed: for sfb0-11, windows 0,1,2. sfb0-5 use slen1, 6-11 use slen2. scfsi is ignored.
  - Mixed: long sfb0-7 slen1, then short sfb3-5 ×3 windows slen1, then short sfb6-11 ×3 windows slen2.
  - slen=0 values consume no bits and no cycles.
- Throughput and fifo_rd:
  - SCF consumes at most 1 bit per clk.
  - fifo_rd=1 in SCF; fifo_rd=huff_ready in HUFF; 0 otherwise.
  - bit_cnt increments per consumed bit.
- SCF→HUFF when the scalefactors are complete. part2_length is captured then.
- SCF truncation: if bit_cnt reaches part2_3_length before the scalefactors are complete:
  - Remaining values stay 0 and trunc_err is set.
  - The state goes to DONE.
- HUFF:
  - huff_ov = fifo_iv; huff_od = fifo_id.
  - huff_last is asserted on the bit where bit_cnt+1 == part2_3_length.
  - HUFF→DONE after that bit is consumed.
  - If part2_3_length == part2_length, HUFF is skipped.
- DONE:
  - done=1 for one cycle, then IDLE.
  - Long values of ch are written back to that channel's store.
  - scalefac_l/scalefac_s are held until the next side_info_iv.
- part2_3_length=0: SCF → DONE with no bits consumed. trunc_err=1 only if some slen is nonzero.
- Latency: done is high the cycle after the last bit is consumed.

Optional Feature:
- Macro: PARSER_HUFF_FWD_EN.
- Defined: HUFF forwarding as above.
- Undefined: part3 bits are consumed and discarded at 1 bit/clk (fifo_rd=1 in HUFF, huff_ready ignored); huff_ov, huff_od and huff_last are tied to 0.

Test Plan:
- Long block, gr=0, ch=0, compress=15 (slen 4/3), part2_3_length=80, fifo always valid, huff_ready=1:
  - part2_length=74 (11·4+10·3).
  - Exactly 6 huff bits forwarded, huff_last on the 6th.
  - done one cycle after bit 80; scalefac_l matches the stimulus.
- Follow-up gr=1, ch=0, scfsi=4'b0101, compress=15:
  - Groups 0 and 2 retained from gr0; only sfb6-10 and 16-20 read.
  - part2_length=5·4+5·3=35.
- Short non-mixed, compress=5 (1/1), part2_3_length=36:
  - 36 bits fill scalefac_s[0..11][0..2]; no huff bits; done.
- Mixed, compress=9 (2/2):
  - part2_length = 8·2+9·2+18·2 = 70.
  - scalefac_s sfb0-2 remain 0.
- Truncation and abandonment:
  - compress=15 long with part2_3_length=20: done after 20 bits, trunc_err=1, sfb5..20 = 0.
  - side_info_iv asserted mid-SCF: no done pulse for the abandoned granule; restart verified.
- Backpressure:
  - huff_ready toggled 1/0 and fifo_iv gaps in HUFF: no bit lost or duplicated; bit_cnt ends equal to part2_3_length.
  - rst mid-HUFF returns all outputs to 0.
